// File: rtl/cluster_unpacker_pkg.sv
// Shared cluster-finder constants used by the receiver-side cluster unpacker.
package cluster_unpacker_pkg;

    localparam int MXCLUSTERS     = 8;
    localparam int MXSBITS        = 64;
    localparam int MXVFATS        = 24;
    localparam int MXSBITSCHAMBER = MXSBITS * MXVFATS;
    localparam int MXADRBITS      = 11;
    localparam int MXCNTBITS      = 3;
    localparam int MXIDXBITS      = (MXCLUSTERS > 1) ? $clog2(MXCLUSTERS) : 1;
    localparam int MXNCLBITS      = 5;
    localparam int MXDROPBITS     = 8;

endpackage

// File: rtl/cluster_mask_1536.sv
// Combinational strip mask for one cluster: bits adr..adr+cnt, clipped at the top of the map.
module cluster_mask_1536
    import cluster_unpacker_pkg::*;
(
    input  logic [MXADRBITS-1:0]      adr,
    input  logic [MXCNTBITS-1:0]      cnt,
    output logic [MXSBITSCHAMBER-1:0] mask
);

    localparam int RUNW = 1 << MXCNTBITS;

    logic [RUNW-1:0]           w_run;
    logic [MXSBITSCHAMBER-1:0] w_run_ext;

    always_comb begin
        w_run = '0;
        for (int i = 0; i < RUNW; i++) begin
            w_run[i] = (i <= int'(cnt));
        end
    end

    // A logical left shift drops anything past bit 1535, giving the clip without wrap;
    // addresses >= 1536 shift the run out entirely.
    assign w_run_ext = {{(MXSBITSCHAMBER-RUNW){1'b0}}, w_run};
    assign mask      = w_run_ext << adr;

endmodule

// File: rtl/cluster_unpacker.sv
// Re-expands a latched frame of clusters into the 1536-bit sbit map, one cluster per clock.
module cluster_unpacker
    import cluster_unpacker_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              latch_in,
    input  logic [MXCLUSTERS*MXADRBITS-1:0]   adr_in,
    input  logic [MXCLUSTERS*MXCNTBITS-1:0]   cnt_in,
    input  logic [MXCLUSTERS-1:0]             vpf_in,
    output logic [MXSBITSCHAMBER-1:0]         vpfs_out,
    output logic                              valid_out,
    output logic [MXNCLBITS-1:0]              nclusters_out,
    output logic                              busy,
    output logic [MXDROPBITS-1:0]             drop_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [MXCLUSTERS-1:0][MXADRBITS-1:0] r_adr;
    logic [MXCLUSTERS-1:0][MXCNTBITS-1:0] r_cnt;
    logic [MXCLUSTERS-1:0]                r_vpf;
    logic [MXIDXBITS-1:0]                 r_idx;
    logic [MXSBITSCHAMBER-1:0]            r_acc;
    logic [MXNCLBITS-1:0]                 r_ncl;

    logic [MXADRBITS-1:0]      w_cur_adr;
    logic [MXCNTBITS-1:0]      w_cur_cnt;
    logic [MXSBITSCHAMBER-1:0] w_mask;
    logic                      w_hit;
    logic                      w_last;
    logic                      w_capture;
    logic                      w_process;
    logic                      w_publish;
    logic                      w_drop;

    assign w_cur_adr = r_adr[r_idx];
    assign w_cur_cnt = r_cnt[r_idx];
    assign w_hit     = r_vpf[r_idx] && (w_cur_adr < MXADRBITS'(MXSBITSCHAMBER));
    assign w_last    = (r_idx == MXIDXBITS'(MXCLUSTERS-1));
    assign busy      = (r_state == EXPAND);

    cluster_mask_1536 u_mask (
        .adr  (w_cur_adr),
        .cnt  (w_cur_cnt),
        .mask (w_mask)
    );

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_process = 1'b0;
        w_publish = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            IDLE: begin
                if (latch_in) begin
                    w_capture = 1'b1;
                    w_next    = EXPAND;
                end
            end
            EXPAND: begin
                w_process = 1'b1;
                w_drop    = latch_in;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_publish = 1'b1;
                // A frame arriving on the publish cycle is taken immediately, no bubble.
                if (latch_in) begin
                    w_capture = 1'b1;
                    w_next    = EXPAND;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_adr         <= '0;
            r_cnt         <= '0;
            r_vpf         <= '0;
            r_idx         <= '0;
            r_acc         <= '0;
            r_ncl         <= '0;
            vpfs_out      <= '0;
            valid_out     <= 1'b0;
            nclusters_out <= '0;
            drop_cnt      <= '0;
        end else begin
            r_state   <= w_next;
            valid_out <= w_publish;
            if (w_capture) begin
                r_adr <= adr_in;
                r_cnt <= cnt_in;
                r_vpf <= vpf_in;
                r_idx <= '0;
                r_acc <= '0;
                r_ncl <= '0;
            end
            if (w_process) begin
                if (w_hit) begin
                    r_acc <= r_acc | w_mask;
                    r_ncl <= r_ncl + MXNCLBITS'(1);
                end
                if (!w_last) begin
                    r_idx <= r_idx + MXIDXBITS'(1);
                end
            end
            if (w_publish) begin
                vpfs_out      <= r_acc;
                nclusters_out <= r_ncl;
            end
            if (w_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + MXDROPBITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_cluster_unpacker.sv
// Directed and randomised scoreboard bench for cluster_unpacker.
module tb_cluster_unpacker;
    import cluster_unpacker_pkg::*;

    localparam int NB = MXSBITSCHAMBER;

    logic                            clock = 1'b0;
    logic                            reset_n = 1'b0;
    logic                            latch_in = 1'b0;
    logic [MXCLUSTERS*MXADRBITS-1:0] adr_in = '0;
    logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in = '0;
    logic [MXCLUSTERS-1:0]           vpf_in = '0;
    logic [NB-1:0]                   vpfs_out;
    logic                            valid_out;
    logic [MXNCLBITS-1:0]            nclusters_out;
    logic                            busy;
    logic [MXDROPBITS-1:0]           drop_cnt;

    cluster_unpacker dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .latch_in      (latch_in),
        .adr_in        (adr_in),
        .cnt_in        (cnt_in),
        .vpf_in        (vpf_in),
        .vpfs_out      (vpfs_out),
        .valid_out     (valid_out),
        .nclusters_out (nclusters_out),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NB-1:0] map;
        int            ncl;
        int            due;
    } exp_t;
    exp_t sbq[$];

    logic [MXADRBITS-1:0] f_adr [MXCLUSTERS];
    logic [MXCNTBITS-1:0] f_cnt [MXCLUSTERS];
    logic                 f_vpf [MXCLUSTERS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_map(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        int first;
        first = -1;
        checks++;
        assert (obs === exp) else begin
            for (int b = NB - 1; b >= 0; b--) begin
                if (obs[b] !== exp[b]) first = b;
            end
            errors++;
            $error("FAIL %s observed_popcount=%0d expected_popcount=%0d first_diff_bit=%0d",
                   tag, $countones(obs), $countones(exp), first);
        end
    endtask

    // Scoreboard: every valid strobe must match the oldest outstanding frame, on its due cycle.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && valid_out === 1'b1) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=1 expected=0 cycle=%0d", cyc);
            end
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("latency_cycle", 64'(cyc), 64'(e.due));
                chk("nclusters", 64'(nclusters_out), 64'(e.ncl));
                chk_map("vpfs_map", vpfs_out, e.map);
            end
        end
    end

    task automatic clear_frame();
        for (int c = 0; c < MXCLUSTERS; c++) begin
            f_adr[c] = '0;
            f_cnt[c] = '0;
            f_vpf[c] = 1'b0;
        end
    endtask

    function automatic logic [NB-1:0] model_map();
        logic [NB-1:0] m;
        int b;
        m = '0;
        for (int c = 0; c < MXCLUSTERS; c++) begin
            if (f_vpf[c] && int'(f_adr[c]) < NB) begin
                for (int j = 0; j <= int'(f_cnt[c]); j++) begin
                    b = int'(f_adr[c]) + j;
                    if (b < NB) m[b] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    function automatic int model_ncl();
        int n;
        n = 0;
        for (int c = 0; c < MXCLUSTERS; c++) begin
            if (f_vpf[c] && int'(f_adr[c]) < NB) n++;
        end
        return n;
    endfunction

    // Drives the current frame for one clock from a negedge; valid is due 9 edges after the latch edge.
    task automatic send_frame(input bit push, input logic [NB-1:0] emap, input int encl);
        exp_t e;
        for (int c = 0; c < MXCLUSTERS; c++) begin
            adr_in[c*MXADRBITS +: MXADRBITS] = f_adr[c];
            cnt_in[c*MXCNTBITS +: MXCNTBITS] = f_cnt[c];
            vpf_in[c]                        = f_vpf[c];
        end
        latch_in = 1'b1;
        if (push) begin
            e.map = emap;
            e.ncl = encl;
            e.due = cyc + 10;
            sbq.push_back(e);
        end
        @(negedge clock);
        latch_in = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clock);
        chk(tag, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        logic [NB-1:0] m;
        logic [NB-1:0] held;
        int k;
        int a;

        clear_frame();
        repeat (3) @(negedge clock);
        chk_map("reset_vpfs", vpfs_out, '0);
        chk("reset_valid", 64'(valid_out), 64'd0);
        chk("reset_ncl", 64'(nclusters_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_drop", 64'(drop_cnt), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single cluster
        clear_frame();
        f_adr[0] = 11'd100; f_cnt[0] = 3'd2; f_vpf[0] = 1'b1;
        m = '0; m[102:100] = 3'b111;
        send_frame(1'b1, m, 1);
        chk("busy_in_expand", 64'(busy), 64'd1);
        wait_drain("drain_single");
        @(negedge clock);
        chk("valid_one_cycle", 64'(valid_out), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);

        // Edge clip plus out-of-range address
        clear_frame();
        f_adr[0] = 11'd1534; f_cnt[0] = 3'd7; f_vpf[0] = 1'b1;
        f_adr[1] = 11'd1536; f_cnt[1] = 3'd3; f_vpf[1] = 1'b1;
        m = '0; m[1535] = 1'b1; m[1534] = 1'b1;
        send_frame(1'b1, m, 1);
        wait_drain("drain_clip");
        chk("clip_no_wrap_bit0", 64'(vpfs_out[0]), 64'd0);

        // Invalid clusters first, valid ones later, overlapping duplicates
        clear_frame();
        f_adr[0] = 11'd50;   f_cnt[0] = 3'd3;
        f_adr[1] = 11'd2000; f_cnt[1] = 3'd7;
        f_adr[5] = 11'd10;   f_cnt[5] = 3'd0; f_vpf[5] = 1'b1;
        f_adr[7] = 11'd10;   f_cnt[7] = 3'd4; f_vpf[7] = 1'b1;
        m = '0; m[14:10] = 5'h1f;
        send_frame(1'b1, m, 2);
        wait_drain("drain_no_early_stop");

        // Full frame
        clear_frame();
        for (int c = 0; c < MXCLUSTERS; c++) begin
            f_adr[c] = (c == 7) ? 11'd773 : MXADRBITS'(c * 200);
            f_cnt[c] = MXCNTBITS'(c);
            f_vpf[c] = 1'b1;
        end
        send_frame(1'b1, model_map(), 8);
        wait_drain("drain_full");

        // Back-to-back A then B, with a dropped latch at E3 of B
        clear_frame();
        f_adr[0] = 11'd300; f_cnt[0] = 3'd1; f_vpf[0] = 1'b1;
        m = '0; m[301:300] = 2'b11;
        send_frame(1'b1, m, 1);
        repeat (8) @(negedge clock);
        clear_frame();
        f_adr[2] = 11'd1000; f_cnt[2] = 3'd4; f_vpf[2] = 1'b1;
        f_adr[6] = 11'd5;    f_cnt[6] = 3'd0; f_vpf[6] = 1'b1;
        held = model_map();
        send_frame(1'b1, held, 2);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_drop_zero", 64'(drop_cnt), 64'd0);
        repeat (2) @(negedge clock);
        clear_frame();
        f_adr[0] = 11'd700; f_cnt[0] = 3'd7; f_vpf[0] = 1'b1;
        send_frame(1'b0, '0, 0);
        chk("drop_one", 64'(drop_cnt), 64'd1);
        wait_drain("drain_b2b");
        repeat (5) @(negedge clock);
        chk_map("outputs_hold", vpfs_out, held);
        chk("ncl_hold", 64'(nclusters_out), 64'd2);

        // Reset in the middle of EXPAND
        clear_frame();
        f_adr[0] = 11'd400; f_cnt[0] = 3'd3; f_vpf[0] = 1'b1;
        send_frame(1'b0, '0, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_map("midreset_vpfs", vpfs_out, '0);
        chk("midreset_valid", 64'(valid_out), 64'd0);
        chk("midreset_ncl", 64'(nclusters_out), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_drop", 64'(drop_cnt), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (15) @(negedge clock);
        clear_frame();
        f_adr[3] = 11'd600; f_cnt[3] = 3'd5; f_vpf[3] = 1'b1;
        m = '0; m[605:600] = 6'h3f;
        send_frame(1'b1, m, 1);
        wait_drain("drain_after_reset");

        // Round trip of random sparse maps of up to 8 clusters, size up to 8
        for (int t = 0; t < 6; t++) begin
            clear_frame();
            m = '0;
            k = int'($urandom_range(1, MXCLUSTERS));
            for (int c = 0; c < MXCLUSTERS; c++) begin
                if (c < k) begin
                    a = c * 192 + int'($urandom_range(0, 183));
                    f_adr[c] = MXADRBITS'(a);
                    f_cnt[c] = MXCNTBITS'($urandom_range(0, 7));
                    f_vpf[c] = 1'b1;
                    for (int j = 0; j <= int'(f_cnt[c]); j++) m[a + j] = 1'b1;
                end else begin
                    f_adr[c] = MXADRBITS'($urandom_range(0, 2047));
                    f_cnt[c] = MXCNTBITS'($urandom_range(0, 7));
                end
            end
            send_frame(1'b1, m, k);
            wait_drain("drain_roundtrip");
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cluster_unpacker.md
Name: cluster_unpacker

Overview:
- Receiver-side counterpart of the first-N-of-1536 cluster finder.
- Takes one latched frame of up to MXCLUSTERS clusters (address, count, valid) and re-expands it into a 1536-bit sbit hit map (24 VFATs x 64 sbits).
- Used in the cluster-loopback/emulation path and as a bench reference for round-trip checks of the cluster packer.
- Processes one cluster per clock with fixed latency, then presents the reconstructed map with a one-cycle valid strobe.

Parameters:
- MXCLUSTERS, 8, clusters per frame (4, 5, 8 or 16 supported).
- MXSBITS, 64, sbits per VFAT.
- MXVFATS, 24, VFATs per chamber; map width MXSBITS*MXVFATS = 1536.
- MXADRBITS, 11, cluster address width.
- MXCNTBITS, 3, cluster count width; cluster size = cnt+1 strips.

Ports:
- clock  in  1  logic clock (160 MHz domain of cluster finder)
- reset_n  in  1  asynchronous active-low reset
- latch_in  in  1  one-cycle pulse: cluster frame valid on adr_in/cnt_in/vpf_in
- adr_in  in  MXCLUSTERS*11  cluster i address at [11*i+10:11*i]
- cnt_in  in  MXCLUSTERS*3  cluster i count at [3*i+2:3*i]
- vpf_in  in  MXCLUSTERS  cluster i valid flag
- vpfs_out  out  1536  reconstructed sbit map, held between frames
- valid_out  out  1  one-cycle strobe, vpfs_out updated
- nclusters_out  out  5  number of clusters with vpf=1 and in-range address in the last frame
- busy  out  1  high while in EXPAND
- drop_cnt  out  8  saturating count of latch_in pulses dropped while busy

Behaviour:
- Reset (async, reset_n=0): state IDLE; vpfs_out=0, valid_out=0, nclusters_out=0, busy=0, drop_cnt=0, internal accumulator and index cleared.
- States: IDLE, EXPAND, DONE.
- IDLE, latch_in=1: capture adr_in/cnt_in/vpf_in into frame registers, clear accumulator and cluster counter, idx=0, go to EXPAND. Otherwise stay in IDLE.
- EXPAND, busy=1:
  - Each edge processes cluster idx.
  - If vpf=1 and adr<1536: OR a mask with bits adr..min(adr+cnt,1535) into the accumulator, and increment the cluster counter.
  - If idx==MXCLUSTERS-1, go to DONE; else idx+1.
- DONE:
  - Load vpfs_out from the accumulator, nclusters_out from the counter, and assert valid_out for exactly one cycle.
  - If latch_in=1 in the same cycle, capture the new frame and go straight to EXPAND (back-to-back, no bubble); else go to IDLE.
- Latency: latch_in sampled at edge E0; clusters processed at E1..E_MXCLUSTERS; outputs update and valid_out rises at edge E_(MXCLUSTERS+1). For MXCLUSTERS=8 this is 9 clocks, independent of hit content.
- latch_in during EXPAND: frame ignored, drop_cnt+1, saturating at 255. The in-progress frame is unaffected.
- Address boundary:
  - adr>=1536: cluster ignored, not counted.
  - adr+cnt>1535: mask clipped at bit 1535, no wrap to bit 0.
- Overlapping or duplicate clusters OR together; no error is flagged.
- vpf=0 with nonzero adr/cnt: ignored. Clusters after an invalid one are still processed (no early stop).
- Outputs hold their last frame values until the next DONE.
- reset_n asserted mid-EXPAND: frame discarded, all outputs cleared. First latch_in after release is accepted normally.

Decomposition:
- MXSBITS, MXVFATS, MXADRBITS, MXCNTBITS, MXCLUSTERS come from the shared constants file used by the cluster finder. The state encoding stays local.
- One combinational sub-module, cluster_mask_1536: inputs adr (11), cnt (3); output a 1536-bit mask with the clip rule.
- Frame capture, FSM, accumulator and counters stay in cluster_unpacker.

Test Plan:
- Single cluster: adr0=100, cnt0=2, vpf0=1, others vpf=0 -> 9 clocks after latch_in, valid_out=1 for 1 cycle; vpfs_out bits 100..102 set only; nclusters_out=1.
- Edge clip: adr=1534, cnt=7, plus adr=1536 with vpf=1 -> only bits 1534,1535 set; bit 0 clear; nclusters_out=1.
- Full frame: 8 clusters at adr 0,200,...,1400, cnt=i, plus second-half address 768+5 -> exact expected map matches the reference model; nclusters_out=8.
- Back-to-back: latch_in on the DONE cycle of frame A -> frame B valid_out exactly 9 clocks later; drop_cnt=0. latch_in at E3 of B -> drop_cnt=1 and B output unchanged.
- Round trip: random sparse 1536-bit maps through the first8 cluster finder into this block -> output equals input whenever the input holds ≤8 clusters of size ≤8.
- Reset mid-EXPAND at E4 -> vpfs_out=0, valid_out never pulses for that frame; next frame decodes correctly.
